// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment controller.
// State encoding, coin encoding/values, amount width and product codes.
package vend_pkg;

  localparam int AMT_W  = 8;
  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_PAY,
    ST_VEND,
    ST_REFUND
  } vend_state_t;

  localparam logic [1:0] COIN_1   = 2'd0;
  localparam logic [1:0] COIN_5   = 2'd1;
  localparam logic [1:0] COIN_10  = 2'd2;
  localparam logic [1:0] COIN_INV = 2'd3;

  localparam logic [AMT_W-1:0] COIN_VAL_1  = 8'd1;
  localparam logic [AMT_W-1:0] COIN_VAL_5  = 8'd5;
  localparam logic [AMT_W-1:0] COIN_VAL_10 = 8'd10;

  localparam logic [CODE_W-1:0] CODE_A = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_B = 4'b0010;
  localparam logic [CODE_W-1:0] CODE_C = 4'b0100;
  localparam logic [CODE_W-1:0] CODE_D = 4'b1000;

  // Face value of a coin; the invalid encoding is worth nothing.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] ctype);
    logic [AMT_W-1:0] v;
    case (ctype)
      COIN_1:  v = COIN_VAL_1;
      COIN_5:  v = COIN_VAL_5;
      COIN_10: v = COIN_VAL_10;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle timeout counter for the PAY state.
// Counts while enabled, restarts on clear, and flags the last cycle of the
// window so the controller can move to refund on the following edge.
module vend_idle_timer #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = ($clog2(LIMIT) < 1) ? 1 : $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && !clear && (count == LAST);

  // Count idle cycles, restarting whenever the controller asks for a clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vend_payment_ctrl.sv
// Vending payment controller: keypad selection, price lookup handshake,
// coin acceptance, dispense with change, and cancel refund.
// Optional feature: define VEND_TIMEOUT_EN to auto-refund after
// TIMEOUT_CYCLES idle cycles in PAY.
module vend_payment_ctrl
  import vend_pkg::*;
#(
  parameter logic [AMT_W-1:0] MAX_CREDIT     = 8'd99,
  parameter int unsigned      TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [CODE_W-1:0] key_code,
  input  logic              coin_valid,
  input  logic [1:0]        coin_type,
  input  logic              cancel,
  input  logic [AMT_W-1:0]  product_price,
  output logic [CODE_W-1:0] product_code,
  output logic [AMT_W-1:0]  credit,
  output logic              busy,
  output logic              dispense,
  output logic [CODE_W-1:0] dispense_code,
  output logic [AMT_W-1:0]  change,
  output logic              change_valid,
  output logic              coin_reject,
  output logic              sel_error
);

  vend_state_t      state;
  logic [AMT_W-1:0] price_q;
  logic [AMT_W:0]   sum9;
  logic             coin_ok;
  logic             coin_take;
  logic             timeout_hit;

  assign busy = (state != ST_IDLE);

  // Evaluate the incoming coin: 9-bit sum so the credit ceiling check never wraps.
  always_comb begin
    sum9      = {1'b0, credit} + {1'b0, coin_value(coin_type)};
    coin_ok   = coin_valid && (coin_type != COIN_INV) && (sum9 <= {1'b0, MAX_CREDIT});
    coin_take = (state == ST_PAY) && coin_ok && !cancel;
  end

`ifdef VEND_TIMEOUT_EN
  vend_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != ST_PAY) || coin_take),
    .enable (state == ST_PAY),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Main controller FSM with registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      price_q       <= '0;
      product_code  <= '0;
      credit        <= '0;
      dispense      <= 1'b0;
      dispense_code <= '0;
      change        <= '0;
      change_valid  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;
    end else begin
      dispense      <= 1'b0;
      dispense_code <= '0;
      change        <= '0;
      change_valid  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (key_valid) begin
            product_code <= key_code;
            state        <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (coin_valid) coin_reject <= 1'b1;
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (coin_valid) coin_reject <= 1'b1;
          price_q <= product_price;
          if (product_price == '0) begin
            sel_error <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_PAY;
          end
        end

        ST_PAY: begin
          if (cancel) begin
            if (coin_valid) coin_reject <= 1'b1;
            state <= ST_REFUND;
          end else if (coin_valid) begin
            if (coin_ok) begin
              credit <= sum9[AMT_W-1:0];
              if (sum9[AMT_W-1:0] >= price_q) state <= ST_VEND;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (timeout_hit) begin
            state <= ST_REFUND;
          end
        end

        ST_VEND: begin
          if (coin_valid) coin_reject <= 1'b1;
          dispense      <= 1'b1;
          dispense_code <= product_code;
          change        <= credit - price_q;
          change_valid  <= 1'b1;
          credit        <= '0;
          state         <= ST_IDLE;
        end

        ST_REFUND: begin
          if (coin_valid) coin_reject <= 1'b1;
          change       <= credit;
          change_valid <= 1'b1;
          credit       <= '0;
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Self-checking bench for vend_payment_ctrl with a registered price lookup model.
// Built with MAX_CREDIT=12 and TIMEOUT_CYCLES=8 so the ceiling and timeout
// cases stay short.
module tb_vend_payment_ctrl;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic [7:0] product_price;
  logic [3:0] product_code;
  logic [7:0] credit;
  logic       busy;
  logic       dispense;
  logic [3:0] dispense_code;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       sel_error;

  int vecCount  = 0;
  int missCount = 0;

  vend_payment_ctrl #(
    .MAX_CREDIT     (8'd12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .cancel        (cancel),
    .product_price (product_price),
    .product_code  (product_code),
    .credit        (credit),
    .busy          (busy),
    .dispense      (dispense),
    .dispense_code (dispense_code),
    .change        (change),
    .change_valid  (change_valid),
    .coin_reject   (coin_reject),
    .sel_error     (sel_error)
  );

  always #5 clk = ~clk;

  // Registered price table standing in for the downstream lookup.
  always @(posedge clk) begin
    if (rst) product_price <= 8'd0;
    else begin
      case (product_code)
        CODE_A:  product_price <= 8'd12;
        CODE_B:  product_price <= 8'd3;
        CODE_C:  product_price <= 8'd5;
        CODE_D:  product_price <= 8'd10;
        default: product_price <= 8'd0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes, let the edge take them, then release them.
  task automatic applyStimulus(input logic kv, input logic [3:0] kc,
                               input logic cv, input logic [1:0] ct, input logic cn);
    key_valid  = kv;
    key_code   = kc;
    coin_valid = cv;
    coin_type  = ct;
    cancel     = cn;
    tick();
    key_valid  = 1'b0;
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask

  // Select a product and advance to the edge where the controller decides on the price.
  task automatic selectProduct(input logic [3:0] code);
    applyStimulus(1'b1, code, 1'b0, COIN_1, 1'b0);
    checkOutput("product_code@E0", 8'(product_code), 8'(code));
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0; key_code = 4'd0;
    coin_valid = 1'b0; coin_type = 2'd0; cancel = 1'b0;
    tick();
    tick();
    checkOutput("reset credit", credit, 8'd0);
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset product_code", 8'(product_code), 8'd0);
    checkOutput("reset change_valid", 8'(change_valid), 8'd0);
    checkOutput("reset dispense", 8'(dispense), 8'd0);
    rst = 1'b0;
    tick();

    $display("[TB] coin in IDLE is returned");
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b0);
    checkOutput("idle coin_reject", 8'(coin_reject), 8'd1);
    checkOutput("idle credit", credit, 8'd0);
    tick();
    checkOutput("idle coin_reject clears", 8'(coin_reject), 8'd0);

    $display("[TB] price 5, pay 10");
    selectProduct(CODE_C);
    checkOutput("t1 busy in PAY", 8'(busy), 8'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_10, 1'b0);
    checkOutput("t1 credit", credit, 8'd10);
    checkOutput("t1 no early dispense", 8'(dispense), 8'd0);
    tick();
    checkOutput("t1 dispense", 8'(dispense), 8'd1);
    checkOutput("t1 dispense_code", 8'(dispense_code), 8'(CODE_C));
    checkOutput("t1 change", change, 8'd5);
    checkOutput("t1 change_valid", 8'(change_valid), 8'd1);
    checkOutput("t1 credit cleared", credit, 8'd0);
    tick();
    checkOutput("t1 dispense one cycle", 8'(dispense), 8'd0);
    checkOutput("t1 change_valid one cycle", 8'(change_valid), 8'd0);
    checkOutput("t1 idle", 8'(busy), 8'd0);

    $display("[TB] price 10, pay 5+1+1+5");
    selectProduct(CODE_D);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b0);
    checkOutput("t2 credit 5", credit, 8'd5);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t2 credit 6", credit, 8'd6);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t2 credit 7", credit, 8'd7);
    checkOutput("t2 no dispense yet", 8'(dispense), 8'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b0);
    checkOutput("t2 credit 12", credit, 8'd12);
    tick();
    checkOutput("t2 dispense", 8'(dispense), 8'd1);
    checkOutput("t2 dispense_code", 8'(dispense_code), 8'(CODE_D));
    checkOutput("t2 change", change, 8'd2);
    tick();

    $display("[TB] non-one-hot selection");
    applyStimulus(1'b1, 4'b0110, 1'b0, COIN_1, 1'b0);
    tick();
    tick();
    checkOutput("t3 sel_error", 8'(sel_error), 8'd1);
    checkOutput("t3 idle", 8'(busy), 8'd0);
    checkOutput("t3 no dispense", 8'(dispense), 8'd0);
    tick();
    checkOutput("t3 sel_error one cycle", 8'(sel_error), 8'd0);

    $display("[TB] cancel with coin");
    selectProduct(CODE_B);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t4 credit 1", credit, 8'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b1);
    checkOutput("t4 coin_reject", 8'(coin_reject), 8'd1);
    checkOutput("t4 credit unchanged", credit, 8'd1);
    tick();
    checkOutput("t4 change_valid", 8'(change_valid), 8'd1);
    checkOutput("t4 refund change", change, 8'd1);
    checkOutput("t4 no dispense", 8'(dispense), 8'd0);
    checkOutput("t4 credit cleared", credit, 8'd0);
    tick();
    checkOutput("t4 idle", 8'(busy), 8'd0);

    $display("[TB] credit ceiling and invalid coin");
    selectProduct(CODE_A);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_10, 1'b0);
    checkOutput("t5 credit 10", credit, 8'd10);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b0);
    checkOutput("t5 over-ceiling reject", 8'(coin_reject), 8'd1);
    checkOutput("t5 credit stays 10", credit, 8'd10);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_INV, 1'b0);
    checkOutput("t5 invalid coin reject", 8'(coin_reject), 8'd1);
    checkOutput("t5 credit still 10", credit, 8'd10);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t5 credit 11", credit, 8'd11);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t5 credit 12", credit, 8'd12);
    tick();
    checkOutput("t5 dispense", 8'(dispense), 8'd1);
    checkOutput("t5 change zero", change, 8'd0);
    checkOutput("t5 change_valid", 8'(change_valid), 8'd1);
    tick();

    $display("[TB] reset in PAY");
    selectProduct(CODE_D);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_5, 1'b0);
    checkOutput("t6 credit 5", credit, 8'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 credit discarded", credit, 8'd0);
    checkOutput("t6 busy", 8'(busy), 8'd0);
    checkOutput("t6 product_code", 8'(product_code), 8'd0);
    tick();
    checkOutput("t6 no refund pulse", 8'(change_valid), 8'd0);

`ifdef VEND_TIMEOUT_EN
    $display("[TB] idle timeout refund");
    selectProduct(CODE_C);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    checkOutput("t7 credit 1", credit, 8'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t7 no early refund", 8'(change_valid), 8'd0);
    end
    checkOutput("t7 still busy", 8'(busy), 8'd1);
    tick();
    checkOutput("t7 timeout change_valid", 8'(change_valid), 8'd1);
    checkOutput("t7 timeout change", change, 8'd1);
    tick();
    checkOutput("t7 idle", 8'(busy), 8'd0);
`else
    $display("[TB] PAY waits without timeout");
    selectProduct(CODE_C);
    applyStimulus(1'b0, 4'd0, 1'b1, COIN_1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("t7 still waiting", 8'(busy), 8'd1);
    checkOutput("t7 no refund", 8'(change_valid), 8'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, COIN_1, 1'b1);
    tick();
    checkOutput("t7 cancel refund", change, 8'd1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/vend_payment_ctrl.md
# vend_payment_ctrl

Payment controller for the vending datapath. Captures a keypad product selection, drives the registered code-to-price lookup, accepts coins until the price is covered, then issues a one-cycle dispense pulse with the change amount. Sits directly upstream and downstream of the price lookup: it supplies `product_code` and consumes the registered `product_price` one cycle later.

## Interface
- `MAX_CREDIT`, 8'd99: highest credit the block will hold. A coin that would exceed it is rejected.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in PAY before auto-refund. Used only with `VEND_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle selection strobe.
- `key_code` in 4: one-hot selection; sampled when `key_valid`=1.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_type` in 2: 0 = 1, 1 = 5, 2 = 10, 3 = invalid.
- `cancel` in 1: level; sampled only in PAY.
- `product_price` in 8: price returned by the lookup, registered one cycle after `product_code`.
- `product_code` out 4: registered selection sent to the lookup.
- `credit` out 8: current inserted amount.
- `busy` out 1: high in every state except IDLE.
- `dispense` out 1: one-cycle pulse.
- `dispense_code` out 4: code being dispensed; valid with `dispense`.
- `change` out 8: refund or change amount; valid with `change_valid`.
- `change_valid` out 1: one-cycle pulse.
- `coin_reject` out 1: one-cycle pulse; the coin is returned.
- `sel_error` out 1: one-cycle pulse; price came back 0.

## Operation
FSM states: IDLE, LOOKUP, CHECK, PAY, VEND, REFUND.
- **IDLE:** `key_valid` → `product_code` <= `key_code`, next state LOOKUP. A coin in IDLE → `coin_reject`.
- **LOOKUP:** waits one cycle while the lookup registers the price. Next state CHECK.
- **CHECK:** `price_q` <= `product_price`.
  - Price 0 (non-one-hot or unknown code): `sel_error` pulse, go to IDLE.
  - Otherwise go to PAY.
- **PAY:** each valid coin adds its value to `credit`.
  - `coin_type`=3, or `credit`+value > `MAX_CREDIT`: `coin_reject` pulse, credit unchanged.
  - `credit` >= `price_q` after the add: go to VEND.
  - `cancel`: go to REFUND. If `cancel` and a coin arrive in the same cycle, cancel wins and the coin gets `coin_reject`.
- **VEND:** one cycle.
  - Outputs: `dispense`=1, `dispense_code`=`product_code`, `change`=`credit`−`price_q`, `change_valid`=1.
  - Clears `credit` and goes to IDLE.
- **REFUND:** one cycle. `change`=`credit`, `change_valid`=1, `credit`<=0, go to IDLE. If `credit` is 0 the pulse still fires with `change`=0.
- `key_valid` outside IDLE is ignored.
- Arithmetic is 8-bit unsigned. The add is computed 9-bit for the `MAX_CREDIT` compare, so the sum never wraps.
- Reset mid-transaction: credit is discarded, no refund pulse.

## Timing
- Reset values: all outputs 0; state IDLE; `price_q`=0.
- Edges below are counted from the `key_valid` edge E0.
  - E0: `product_code` updates.
  - E1: lookup output valid.
  - E2: state is PAY.
- First coin accepted in PAY (cycle after E2).
- Coin to `credit` update: 1 cycle.
- Paying coin at edge Ek: `dispense`/`change_valid` high for cycle Ek+1..Ek+2 only. Back to IDLE after Ek+2.
- `dispense` and `change_valid` are coincident.
- `sel_error`, `coin_reject`, `dispense` and `change_valid` are never high more than one consecutive cycle.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A counter runs in PAY and resets on every accepted coin.
  - On reaching `TIMEOUT_CYCLES`−1 with no coin, the next state is REFUND (same as cancel).
  - The counter clears on leaving PAY.
- `VEND_TIMEOUT_EN` undefined: no counter logic; PAY waits indefinitely; `TIMEOUT_CYCLES` is unused.

## Structure
- Package `vend_pkg`:
  - FSM state enum
  - coin-type encoding and coin value constants (1, 5, 10)
  - price/credit width constant (8)
  - one-hot product code constants
- Sub-module `vend_idle_timer`: timeout counter with clear, enable and expiry pulse. Instantiated only under `VEND_TIMEOUT_EN`.

## Test plan
- Select 4'b0100 (price 5), insert 10 → one `dispense` with `dispense_code`=4'b0100, `change`=5, `credit` back to 0.
- Select 4'b1000 (price 10), insert 5, 1, 1, 5 → dispense on the fourth coin, `change`=2.
- Select 4'b0110 → `sel_error` pulse at E2, state IDLE, no dispense.
- Select 4'b0010, insert 1, assert `cancel` together with a 5 coin → `coin_reject`=1, refund `change`=1, no dispense.
- Insert coins up to 95, then a 10 (price 10, `MAX_CREDIT`=99, done with code and lookup price forced to 10 only after credit 95; alternatively run with `MAX_CREDIT`=8'd12 and insert 10 then 5) → 5 rejected, `credit` stays 10, then vend with `change`=0.
- With `VEND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: select 4'b0100, insert 1, wait → refund `change`=1 after 8 idle cycles. Also assert `rst` in PAY with credit 5 → all outputs 0, no `change_valid`.
